// File: rtl/spc7110_bank_mapper.sv
// spc7110_bank_mapper
// Registered SPC7110 address translator. It owns the data-ROM bank-switch
// registers and the save-RAM enable, and turns a synchronised SNES address
// into an SRAM0 address over a two-stage pipeline (ADDR_STB -> ADDR_VALID
// is two clocks).
// Optional feature: define SPC7110_READBACK_EN to drive REG_DATA_OUT with
// register read-back data. Without it REG_DATA_OUT is tied low.
//
// Write FSM states:
//   state    | meaning
//   S_IDLE   | no register write in progress
//   S_ARMED  | SNES_WR_N low on a register address, data being captured
//   S_COMMIT | SNES_WR_N released, captured data written this cycle
module spc7110_bank_mapper #(
  parameter int unsigned NUM_WIN      = 3,
  parameter int unsigned BANK_W       = 3,
  parameter logic [15:0] REG_BASE     = 16'h4830,
  parameter logic [23:0] SAVERAM_BASE = 24'hE00000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [23:0] SNES_ADDR,
  input  logic        ADDR_STB,
  input  logic        SNES_WR_N,
  input  logic [7:0]  SNES_DATA_IN,
  input  logic [23:0] ROM_MASK,
  input  logic [23:0] SAVERAM_MASK,
  output logic [23:0] ROM_ADDR,
  output logic        ROM_HIT,
  output logic        IS_SAVERAM,
  output logic        ADDR_VALID,
  output logic [7:0]  REG_DATA_OUT,
  output logic        REG_RD_HIT
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COMMIT} wr_state_e;

  // Register window: any bank with bit22 clear, offsets REG_BASE..REG_BASE+NUM_WIN.
  function automatic logic in_reg_win(input logic [23:0] a);
    logic [15:0] off;
    off = a[15:0] - REG_BASE;
    return !a[22] && (a[15:0] >= REG_BASE) && (off <= 16'(NUM_WIN));
  endfunction

  logic [BANK_W-1:0] bank_q [NUM_WIN];
  logic              sram_en_q;

  wr_state_e   state_q, state_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  wsel_q, wsel_d;
  logic [15:0] wr_off;
  logic        commit;

  logic [23:0]       addr_q;
  logic [BANK_W-1:0] snap_q, snap_d;
  logic              v1_q;
  logic              win_q;

  logic [23:0] rom_addr_q, rom_addr_d;
  logic        rom_hit_q, rom_hit_d;
  logic        is_sav_q, is_sav_d;
  logic        valid_q;

  // Select the bank register the incoming address will use.
  always_comb begin
    snap_d = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (SNES_ADDR[22] && SNES_ADDR[21:20] == 2'(i + 1)) snap_d = bank_q[i];
    end
  end

  // Write FSM next-state logic and data capture.
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    wsel_d  = wsel_q;
    commit  = 1'b0;
    wr_off  = addr_q[15:0] - REG_BASE;
    case (state_q)
      S_IDLE: begin
        if (!SNES_WR_N && win_q) begin
          state_d = S_ARMED;
          wdata_d = SNES_DATA_IN;
          wsel_d  = wr_off[1:0];
        end
      end
      S_ARMED: begin
        if (ADDR_STB && !in_reg_win(SNES_ADDR)) begin
          state_d = S_IDLE;
        end else if (SNES_WR_N) begin
          state_d = S_COMMIT;
        end else begin
          wdata_d = SNES_DATA_IN;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write FSM state and captured data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      wdata_q <= '0;
      wsel_q  <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      wsel_q  <= wsel_d;
    end
  end

  // Configuration registers, updated in the COMMIT cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sram_en_q <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) bank_q[i] <= BANK_W'(i);
    end else if (commit) begin
      if (wsel_q == 2'd0) sram_en_q <= wdata_q[7];
      for (int i = 0; i < NUM_WIN; i++) begin
        if (wsel_q == 2'(i + 1)) bank_q[i] <= wdata_q[BANK_W-1:0];
      end
    end
  end

`ifdef SPC7110_READBACK_EN
  logic [7:0]  rd_q, rd_d;
  logic [15:0] rd_off;

  // Read-back mux for the address being strobed.
  always_comb begin
    rd_d   = 8'h00;
    rd_off = SNES_ADDR[15:0] - REG_BASE;
    if (rd_off == 16'd0) rd_d = {sram_en_q, 7'b0};
    for (int i = 0; i < NUM_WIN; i++) begin
      if (rd_off == 16'(i + 1)) rd_d = 8'(bank_q[i]);
    end
  end
`endif

  // Stage 1: latch the address and snapshot its bank register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= '0;
      snap_q <= '0;
      win_q  <= 1'b0;
      v1_q   <= 1'b0;
`ifdef SPC7110_READBACK_EN
      rd_q   <= '0;
`endif
    end else begin
      v1_q <= ADDR_STB;
      if (ADDR_STB) begin
        addr_q <= SNES_ADDR;
        snap_q <= snap_d;
        win_q  <= in_reg_win(SNES_ADDR);
`ifdef SPC7110_READBACK_EN
        rd_q   <= rd_d;
`endif
      end
    end
  end

  // Stage 2 decode: save RAM, PROM, bank windows and low-bank ROM.
  always_comb begin
    logic [BANK_W:0] sum;
    logic [3:0]      blk;
    logic [23:0]     rom_lin;
    logic [23:0]     win_addr;
    logic            rom_dec;
    logic [23:0]     rom_a;
    sum      = {1'b0, snap_q} + {{BANK_W{1'b0}}, 1'b1};
    blk      = 4'(sum);
    rom_lin  = {3'b0, addr_q[20:0]} & ROM_MASK;
    win_addr = {blk, addr_q[19:0]} & ROM_MASK;
    is_sav_d = sram_en_q & SAVERAM_MASK[0] & !addr_q[22] & addr_q[21]
             & (addr_q[14:13] == 2'b11) & !addr_q[15];
    rom_dec  = 1'b0;
    rom_a    = '0;
    if (addr_q[22]) begin
      rom_dec = 1'b1;
      // Windows beyond NUM_WIN fall through to PROM mirrors.
      if (addr_q[21:20] != 2'd0 && addr_q[21:20] <= 2'(NUM_WIN)) rom_a = win_addr;
      else rom_a = rom_lin;
    end else if (addr_q[15]) begin
      rom_dec = 1'b1;
      rom_a   = rom_lin;
    end
    rom_hit_d = rom_dec | is_sav_d;
    if (is_sav_d)
      rom_addr_d = SAVERAM_BASE + ({6'b0, addr_q[20:16], addr_q[12:0]} & SAVERAM_MASK);
    else
      rom_addr_d = rom_a;
  end

  // Stage 2 registers; outputs hold between ADDR_VALID pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rom_addr_q <= '0;
      rom_hit_q  <= 1'b0;
      is_sav_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        rom_addr_q <= rom_addr_d;
        rom_hit_q  <= rom_hit_d;
        is_sav_q   <= is_sav_d;
      end
    end
  end

  assign ROM_ADDR   = rom_addr_q;
  assign ROM_HIT    = rom_hit_q;
  assign IS_SAVERAM = is_sav_q;
  assign ADDR_VALID = valid_q;
  assign REG_RD_HIT = win_q;
`ifdef SPC7110_READBACK_EN
  assign REG_DATA_OUT = rd_q;
`else
  assign REG_DATA_OUT = 8'h00;
`endif

  logic unused_ok;
  assign unused_ok = ^{SNES_ADDR[23], wdata_q, wr_off};

endmodule

// File: tb/tb_spc7110_bank_mapper.sv
// Directed bench for spc7110_bank_mapper with hand-computed expectations.
module tb_spc7110_bank_mapper;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [23:0] SNES_ADDR = '0;
  logic        ADDR_STB = 1'b0;
  logic        SNES_WR_N = 1'b1;
  logic [7:0]  SNES_DATA_IN = '0;
  logic [23:0] ROM_MASK = 24'hFFFFFF;
  logic [23:0] SAVERAM_MASK = 24'h001FFF;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_SAVERAM;
  logic        ADDR_VALID;
  logic [7:0]  REG_DATA_OUT;
  logic        REG_RD_HIT;

  int n_chk  = 0;
  int n_pass = 0;

  spc7110_bank_mapper dut (
    .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .ADDR_STB(ADDR_STB),
    .SNES_WR_N(SNES_WR_N), .SNES_DATA_IN(SNES_DATA_IN), .ROM_MASK(ROM_MASK),
    .SAVERAM_MASK(SAVERAM_MASK), .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT),
    .IS_SAVERAM(IS_SAVERAM), .ADDR_VALID(ADDR_VALID),
    .REG_DATA_OUT(REG_DATA_OUT), .REG_RD_HIT(REG_RD_HIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe(input logic [23:0] a);
    SNES_ADDR = a;
    ADDR_STB  = 1'b1;
    tick();
    ADDR_STB  = 1'b0;
  endtask

  task automatic access(input string tag, input logic [23:0] a, input logic [23:0] ea,
                        input logic eh, input logic es);
    strobe(a);
    chk({tag, "_v1"}, ADDR_VALID, 0);
    tick();
    chk({tag, "_v2"}, ADDR_VALID, 1);
    chk({tag, "_addr"}, ROM_ADDR, ea);
    chk({tag, "_hit"}, ROM_HIT, eh);
    chk({tag, "_sav"}, IS_SAVERAM, es);
  endtask

  // Returns during the COMMIT cycle; registers update on the next edge.
  task automatic write_reg(input logic [23:0] a, input logic [7:0] d);
    strobe(a);
    SNES_DATA_IN = d;
    SNES_WR_N    = 1'b0;
    tick(); tick(); tick();
    SNES_WR_N    = 1'b1;
    SNES_DATA_IN = 8'hFF;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, ROM_ADDR, 0);
    chk({tag, "_hit"}, ROM_HIT, 0);
    chk({tag, "_sav"}, IS_SAVERAM, 0);
    chk({tag, "_valid"}, ADDR_VALID, 0);
    chk({tag, "_rdhit"}, REG_RD_HIT, 0);
    chk({tag, "_rdata"}, REG_DATA_OUT, 0);
  endtask

  initial begin
    #1 RST_N = 1'b0;
    tick(); tick();
    chk_zero("rst");
    RST_N = 1'b1;
    tick();

    access("win0", 24'hD12345, 24'h112345, 1, 0);
    tick();
    chk("pulse", ADDR_VALID, 0);
    chk("hold", ROM_ADDR, 24'h112345);
    access("prom", 24'hC12345, 24'h012345, 1, 0);
    access("lorom", 24'h008000, 24'h008000, 1, 0);
    access("nohit", 24'h000100, 24'h000000, 0, 0);
    access("win2", 24'hF54321, 24'h354321, 1, 0);

    strobe(24'h004832);
    chk("rdhit_b1", REG_RD_HIT, 1);
`ifdef SPC7110_READBACK_EN
    chk("rdata_b1", REG_DATA_OUT, 8'h01);
`else
    chk("rdata_b1", REG_DATA_OUT, 8'h00);
`endif
    strobe(24'h004833);
    chk("rdhit_top", REG_RD_HIT, 1);
    strobe(24'h004834);
    chk("rdhit_past", REG_RD_HIT, 0);
    strobe(24'h00482F);
    chk("rdhit_below", REG_RD_HIT, 0);
    strobe(24'h404830);
    chk("rdhit_b22", REG_RD_HIT, 0);
    tick();

    write_reg(24'h004832, 8'h05);
    tick();
    access("bank1w", 24'hE00010, 24'h600010, 1, 0);

    write_reg(24'h004830, 8'h80);
    tick();
    access("sav0", 24'h306000, 24'hE00000, 1, 1);
    access("sav1", 24'h316123, 24'hE00123, 1, 1);
`ifdef SPC7110_READBACK_EN
    strobe(24'h004830);
    chk("rdata_en", REG_DATA_OUT, 8'h80);
    tick();
`endif
    write_reg(24'h004830, 8'h00);
    tick();
    access("savoff", 24'h306000, 24'h000000, 0, 0);

    // Strobe lands in the COMMIT cycle: old bank0 first, new bank0 next.
    write_reg(24'h004831, 8'h04);
    SNES_ADDR = 24'hD00000;
    ADDR_STB  = 1'b1;
    tick();
    tick();
    ADDR_STB  = 1'b0;
    chk("same_v", ADDR_VALID, 1);
    chk("same_old", ROM_ADDR, 24'h100000);
    tick();
    chk("b2b_v", ADDR_VALID, 1);
    chk("b2b_new", ROM_ADDR, 24'h500000);
    tick();
    chk("b2b_end", ADDR_VALID, 0);

    write_reg(24'h004831, 8'h07);
    tick();
    ROM_MASK = 24'h7FFFFF;
    access("wrap", 24'hD00000, 24'h000000, 1, 0);

    // Armed write aborted by a strobe outside the register window.
    strobe(24'h004831);
    SNES_DATA_IN = 8'h02;
    SNES_WR_N    = 1'b0;
    tick(); tick();
    strobe(24'hD00000);
    SNES_WR_N = 1'b1;
    tick(); tick(); tick();
    access("abort", 24'hD00000, 24'h000000, 1, 0);

    // Reset while ARMED discards the write and restores default banks.
    ROM_MASK = 24'hFFFFFF;
    strobe(24'h004831);
    SNES_DATA_IN = 8'h06;
    SNES_WR_N    = 1'b0;
    tick(); tick();
    RST_N     = 1'b0;
    SNES_WR_N = 1'b1;
    #2;
    chk_zero("rst_armed");
    tick();
    RST_N = 1'b1;
    tick(); tick();
    access("rb0", 24'hD00000, 24'h100000, 1, 0);
    access("rb1", 24'hE00000, 24'h200000, 1, 0);
    access("rb2", 24'hF00000, 24'h300000, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spc7110_bank_mapper.md
Name: spc7110_bank_mapper

Overview:
- Registered, parametrised successor to the combinational SPC7110 address decoder.
- Owns the data-ROM bank-switch registers internally instead of taking them as inputs, and supports NUM_WIN switchable 1 MB windows instead of a fixed D/E/F triple.
- Translates SNES bus addresses into SRAM0 addresses through a 2-stage pipeline.
- Sits between the SNES bus synchronisers and the SRAM0 arbiter.

Parameters:
- NUM_WIN, 3, number of bank-switchable 1 MB windows; window i covers banks $D0+16*i..$DF+16*i; legal 1..3.
- BANK_W, 3, width of each bank-select register.
- REG_BASE, 16'h4830, I/O offset of the SRAM-enable register; bank register i sits at REG_BASE+1+i.
- SAVERAM_BASE, 24'hE00000, SRAM0 base address of save RAM.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- SNES_ADDR  in  24  SNES address, already synchronised.
- ADDR_STB  in  1  one-cycle pulse: SNES_ADDR is stable and new.
- SNES_WR_N  in  1  synchronised SNES write strobe, active low.
- SNES_DATA_IN  in  8  SNES write data.
- ROM_MASK  in  24  ROM size mask.
- SAVERAM_MASK  in  24  save RAM size mask.
- ROM_ADDR  out  24  translated SRAM0 address.
- ROM_HIT  out  1  SRAM0 access required.
- IS_SAVERAM  out  1  address maps to save RAM.
- ADDR_VALID  out  1  one-cycle pulse: ROM_ADDR/ROM_HIT/IS_SAVERAM updated.
- REG_DATA_OUT  out  8  register read-back data.
- REG_RD_HIT  out  1  current address hits the register window.

Behaviour:
- Reset (async, RST_N low). All outputs are 0. sram_en=0. Bank register i resets to i, so windows D/E/F map to blocks 1/2/3. Write FSM goes to IDLE. Pipeline valid bits clear.
- Register window: {SNES_ADDR[22], SNES_ADDR[15:0]} in {0, REG_BASE..REG_BASE+NUM_WIN}, any bank with bit22=0. REG_RD_HIT is registered 1 cycle after ADDR_STB.
- Write FSM, IDLE -> ARMED: SNES_WR_N=0 while the latched address is in the register window.
- Write FSM, ARMED -> COMMIT: SNES_WR_N rises. Data is captured from SNES_DATA_IN on the last cycle SNES_WR_N was low.
- Write FSM, COMMIT -> IDLE: unconditional, one cycle. The register update happens in this cycle.
- Write FSM, ARMED and ADDR_STB leaves the window: return to IDLE, no commit.
- Register write contents: bank registers take SNES_DATA_IN[BANK_W-1:0]. sram_en takes SNES_DATA_IN[7].
- Stage 1 (ADDR_STB): latch SNES_ADDR and snapshot the selected bank register.
  - A COMMIT in the same cycle does not affect the snapshot; the old value is used.
- Stage 2 (next cycle): compute and register the outputs, and pulse ADDR_VALID.
  - Latency is exactly 2 cycles from ADDR_STB to ADDR_VALID.
  - Back-to-back ADDR_STB is fully pipelined.
- Save RAM decode:
  - Condition: sram_en & SAVERAM_MASK[0] & !A[22] & A[21] & A[14:13]==2'b11 & !A[15].
  - Address: SAVERAM_BASE + ({A[20:16], A[12:0]} & SAVERAM_MASK).
- PROM: A[22]=1, A[21:20]=0 -> {3'b0, A[20:0]} & ROM_MASK.
- Window i: A[22]=1 and A[21:20]=i+1.
  - Address: ({bank_i+1, A[19:0]} & ROM_MASK).
  - The sum bank_i+1 is (BANK_W+1) bits wide. The result is placed at bits [23:20] and truncated to 4 bits, so blocks above 15 wrap.
- Windows with i >= NUM_WIN map as PROM mirrors.
- Low-bank ROM: A[22]=0 & A[15]=1 -> ({3'b0, A[20:0]} & ROM_MASK).
- ROM_HIT = ROM decode | IS_SAVERAM.
- Non-hit addresses give ROM_ADDR=0.
- All outputs hold their values between ADDR_VALID pulses.
- Reset mid-write discards the pending commit.

Optional Feature:
- Macro: SPC7110_READBACK_EN.
- Defined: REG_DATA_OUT returns {sram_en, 7'b0} at REG_BASE, and {0-padded bank_i} at REG_BASE+1+i. Valid with REG_RD_HIT.
- Undefined: REG_DATA_OUT is tied to 8'h00 and the read-back mux is omitted. REG_RD_HIT is still generated.

Test Plan:
- Reset, then ADDR_STB with $D12345, ROM_MASK=$FFFFFF -> ADDR_VALID 2 cycles later, ROM_ADDR=$112345, ROM_HIT=1.
- Write $05 to $004832 (SNES_WR_N low 3 cycles, then high) -> bank1=5; ADDR_STB $E00010 -> ROM_ADDR=$600010.
- Write $80 to $004830, then ADDR_STB $306000 with SAVERAM_MASK=$001FFF -> IS_SAVERAM=1, ROM_ADDR=$E00000. Same access with sram_en=0 -> IS_SAVERAM=0, ROM_HIT=0.
- ADDR_STB $D00000 in the same cycle bank0 commits 4 (old value 0) -> first result $100000; next ADDR_STB $D00000 -> $500000.
- Bank0=7, BANK_W=3 -> ROM_ADDR[23:20]=8 masked by ROM_MASK=$7FFFFF -> $000000.
- RST_N pulsed low while the FSM is ARMED -> no register change, all outputs 0, banks back to 0/1/2.
